tdc_measure_sequencer: RTL and testbench

Controller that sequences the 8-bit time-to-digital converter through a burst of 2^N_AVG_LOG2 conversions per request, and returns their truncated average.
- Drives the TDC start pulse and watches TDC ready.
- Captures and accumulates each count.
- Enforces a per-conversion timeout.
- Presents the result to a system requester with a req/ack handshake.
Sits between the system control logic and the TDC top.

---
 rtl/tdc_pkg.sv | 31 +++
 rtl/tdc_measure_sequencer_if.sv | 28 ++
 rtl/tdc_cycle_timer.sv | 32 +++
 rtl/tdc_measure_sequencer.sv | 149 ++++++++++++++
 tb/tb_tdc_measure_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement sequencer.
// Holds the state enum, default widths and width helper functions.
package tdc_pkg;

   localparam int TDC_COUNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_READY,
      CAPTURE,
      GAP,
      DONE
   } tdc_seq_state_t;

   // Accumulator wide enough to sum 2^n samples of cw bits without overflow.
   function automatic int acc_width(input int cw, input int n);
      return cw + n;
   endfunction

   // Timer holds (interval - 1), so clog2 of the largest interval fits.
   function automatic int timer_width(input int a, input int b,
                                      input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/tdc_measure_sequencer_if.sv
// Handshake bundle between requester, sequencer and TDC.
// master: requester/TDC side; slave: sequencer side.
interface tdc_measure_sequencer_if
   import tdc_pkg::*;
#(
   parameter int COUNT_W = TDC_COUNT_W
) ();

   logic               req;
   logic               ack;
   logic               busy;
   logic [COUNT_W-1:0] result;
   logic               timeout_err;
   logic               tdc_start;
   logic               tdc_ready;
   logic [COUNT_W-1:0] tdc_count;

   modport master (
      output req, tdc_ready, tdc_count,
      input  ack, busy, result, timeout_err, tdc_start
   );

   modport slave (
      input  req, tdc_ready, tdc_count,
      output ack, busy, result, timeout_err, tdc_start
   );

endinterface

// File: rtl/tdc_cycle_timer.sv
// Loadable down-counter with zero flag for interval timing.
// Ports: clk, rst, load_i, val_i (load value), zero_o (count == 0).
module tdc_cycle_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tdc_measure_sequencer.sv
// Runs a burst of 2^N_AVG_LOG2 TDC conversions and returns the average.
// Ports: clk, rst, bus (slave: req/ack/busy/result/err, tdc start/ready/count).
module tdc_measure_sequencer
   import tdc_pkg::*;
#(
   parameter int COUNT_W         = TDC_COUNT_W,
   parameter int N_AVG_LOG2      = 3,
   parameter int START_PULSE_CYC = 5,
   parameter int GAP_CYC         = 2,
   parameter int TIMEOUT_CYC     = 1000
) (
   input logic                    clk,
   input logic                    rst,
   tdc_measure_sequencer_if.slave bus
);

   localparam int AW = acc_width(COUNT_W, N_AVG_LOG2);
   localparam int TW = timer_width(START_PULSE_CYC, GAP_CYC,
                                   TIMEOUT_CYC);
   localparam int IW = N_AVG_LOG2 + 1;

   localparam logic [IW-1:0] N_SAMP = IW'(1 << N_AVG_LOG2);
   localparam logic [TW-1:0] T_START = TW'(START_PULSE_CYC - 1);
   localparam logic [TW-1:0] T_GAP =
      TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [TW-1:0] T_TMO = TW'(TIMEOUT_CYC - 1);

   tdc_seq_state_t state_q, state_d;

   logic [AW-1:0]      acc_q, acc_d, acc_sum;
   logic [IW-1:0]      idx_q, idx_d, idx_inc;
   logic               seen_q, seen_d;
   logic [COUNT_W-1:0] res_q, res_d;
   logic               err_q, err_d;

   logic          t_load;
   logic [TW-1:0] t_val;
   logic          t_zero;

   tdc_cycle_timer #(.W(TW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (t_load),
      .val_i  (t_val),
      .zero_o (t_zero)
   );

   assign acc_sum = acc_q + AW'(bus.tdc_count);
   assign idx_inc = idx_q + IW'(1);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      seen_d  = seen_q;
      res_d   = res_q;
      err_d   = err_q;
      t_load  = 1'b0;
      t_val   = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               acc_d   = '0;
               idx_d   = '0;
               seen_d  = 1'b0;
               t_load  = 1'b1;
               t_val   = T_START;
               state_d = START;
            end
         end
         START: begin
            if (!bus.tdc_ready) seen_d = 1'b1;
            if (t_zero) begin
               t_load  = 1'b1;
               t_val   = T_TMO;
               state_d = WAIT_READY;
            end
         end
         WAIT_READY: begin
            if (!bus.tdc_ready) seen_d = 1'b1;
            // A ready level never seen low since START is stale.
            if (bus.tdc_ready && seen_q) begin
               state_d = CAPTURE;
            end else if (t_zero) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         CAPTURE: begin
            acc_d = acc_sum;
            idx_d = idx_inc;
            if (idx_inc == N_SAMP) begin
               res_d   = COUNT_W'(acc_sum >> N_AVG_LOG2);
               err_d   = 1'b0;
               state_d = DONE;
            end else if (GAP_CYC == 0) begin
               seen_d  = 1'b0;
               t_load  = 1'b1;
               t_val   = T_START;
               state_d = START;
            end else begin
               t_load  = 1'b1;
               t_val   = T_GAP;
               state_d = GAP;
            end
         end
         GAP: begin
            if (t_zero) begin
               seen_d  = 1'b0;
               t_load  = 1'b1;
               t_val   = T_START;
               state_d = START;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         seen_q  <= 1'b0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         seen_q  <= seen_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign bus.tdc_start   = (state_q == START);
   assign bus.busy        = (state_q != IDLE);
   assign bus.ack         = (state_q == DONE);
   assign bus.result      = res_q;
   assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_tdc_measure_sequencer.sv
// Directed bench for tdc_measure_sequencer with a reactive TDC model.
// Modes: 0 ideal, 1 never ready, 2 stale-high ready then low/high.
module tb_tdc_measure_sequencer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tdc_measure_sequencer_if #(.COUNT_W(8)) bus ();

   tdc_measure_sequencer #(
      .COUNT_W         (8),
      .N_AVG_LOG2      (3),
      .START_PULSE_CYC (5),
      .GAP_CYC         (2),
      .TIMEOUT_CYC     (1000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int vectors = 0;
   int miscompares = 0;

   int mode = 0;
   int ramp = 0;
   int base = 0;
   int pidx = 0;
   int sf = 100;
   logic m_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.tdc_start === 1'b1) begin
         if (!m_prev) begin
            bus.tdc_count = 8'(base + ((ramp != 0) ? pidx : 0));
            pidx++;
         end
         sf = 0;
         bus.tdc_ready = (mode == 2);
      end else begin
         sf++;
         if (mode == 0)      bus.tdc_ready = (sf >= 2);
         else if (mode == 1) bus.tdc_ready = 1'b0;
         else                bus.tdc_ready = !(sf >= 4 && sf <= 7);
      end
      m_prev = (bus.tdc_start === 1'b1);
   end

   int cyc = 0;
   int rise_n = 0, fall_n = 0, ack_n = 0;
   int rise_cyc = 0, fall_cyc = 0, ack_cyc = 0;
   int w = 0, minw = 999, maxw = 0;
   int g = -1000, gmin = 999, gmax = 0;
   logic [7:0] ack_res = '0;
   logic ack_err = 1'b0;
   logic mon_prev = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (bus.ack === 1'b1) begin
         ack_n++;
         ack_cyc = cyc;
         ack_res = bus.result;
         ack_err = bus.timeout_err;
         g = -1000;
      end
      if (bus.tdc_start === 1'b1) begin
         if (!mon_prev) begin
            rise_n++;
            rise_cyc = cyc;
            w = 0;
            if (g > 0) begin
               if (g < gmin) gmin = g;
               if (g > gmax) gmax = g;
            end
         end
         w++;
      end else begin
         if (mon_prev) begin
            fall_n++;
            fall_cyc = cyc;
            if (w < minw) minw = w;
            if (w > maxw) maxw = w;
            g = 0;
         end
         g++;
      end
      mon_prev = (bus.tdc_start === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clr();
      rise_n = 0;
      fall_n = 0;
      minw = 999;
      maxw = 0;
      gmin = 999;
      gmax = 0;
      ack_n = 0;
   endtask

   task automatic wait_ack(input int budget);
      int n0;
      n0 = ack_n;
      for (int i = 0; i < budget && ack_n == n0; i++) tick(1);
      chk("ack_seen", 32'(ack_n - n0), 1);
   endtask

   task automatic pulse_req();
      bus.req = 1'b1;
      tick(1);
      bus.req = 1'b0;
   endtask

   int n_before;
   int a;
   int r0;

   initial begin
      rst = 1'b1;
      bus.req = 1'b0;
      tick(3);
      chk("rst_ack", bus.ack, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_start", bus.tdc_start, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_err", bus.timeout_err, 0);
      rst = 1'b0;
      tick(2);

      // 1: constant 40
      mode = 0; ramp = 0; base = 40; pidx = 0;
      clr();
      pulse_req();
      chk("t1_start_rise", bus.tdc_start, 1);
      chk("t1_busy", bus.busy, 1);
      wait_ack(400);
      chk("t1_busy_at_ack", bus.busy, 1);
      chk("t1_result", ack_res, 40);
      chk("t1_err", ack_err, 0);
      chk("t1_pulses", rise_n, 8);
      chk("t1_minw", minw, 5);
      chk("t1_maxw", maxw, 5);
      chk("t1_gmin", gmin, 5);
      chk("t1_gmax", gmax, 5);
      tick(1);
      chk("t1_busy_after", bus.busy, 0);
      tick(20);
      chk("t1_one_ack", ack_n, 1);

      // 2: ramp 10..17
      mode = 0; ramp = 1; base = 10; pidx = 0;
      clr();
      pulse_req();
      wait_ack(400);
      chk("t2_result", ack_res, 13);
      chk("t2_err", ack_err, 0);
      tick(5);
      chk("t2_hold", bus.result, 13);

      // 3: timeout
      mode = 1; ramp = 0; base = 0; pidx = 0;
      clr();
      pulse_req();
      wait_ack(1200);
      chk("t3_latency", 32'(ack_cyc - fall_cyc), 1000);
      chk("t3_err", ack_err, 1);
      chk("t3_result", ack_res, 0);
      chk("t3_pulses", rise_n, 1);
      tick(3);

      // 4: stale ready then low/high
      mode = 2; ramp = 1; base = 100; pidx = 0;
      clr();
      pulse_req();
      wait_ack(600);
      chk("t4_result", ack_res, 103);
      chk("t4_err", ack_err, 0);
      chk("t4_pulses", rise_n, 8);
      chk("t4_gmin", gmin, 11);
      chk("t4_gmax", gmax, 11);
      tick(3);

      // 5: reset in third WAIT_READY
      mode = 0; ramp = 1; base = 50; pidx = 0;
      clr();
      pulse_req();
      for (int i = 0; i < 200 && fall_n < 3; i++) tick(1);
      chk("t5_reach", fall_n, 3);
      rst = 1'b1;
      tick(1);
      chk("t5_start", bus.tdc_start, 0);
      chk("t5_busy", bus.busy, 0);
      chk("t5_ack", bus.ack, 0);
      chk("t5_result", bus.result, 0);
      n_before = ack_n;
      tick(3);
      rst = 1'b0;
      tick(3);
      chk("t5_no_ack", ack_n, n_before);
      base = 20; pidx = 0;
      clr();
      pulse_req();
      wait_ack(400);
      chk("t5_new_result", ack_res, 23);
      chk("t5_new_err", ack_err, 0);
      chk("t5_new_pulses", rise_n, 8);
      tick(3);

      // 6: back-to-back bursts at full scale
      mode = 0; ramp = 0; base = 255; pidx = 0;
      clr();
      bus.req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ack(400);
         chk("t6_result", ack_res, 255);
         chk("t6_err", ack_err, 0);
         a = ack_cyc;
         if (k == 2) begin
            bus.req = 1'b0;
         end else begin
            r0 = rise_n;
            for (int i = 0; i < 10 && rise_n == r0; i++) tick(1);
            chk("t6_spacing", 32'(rise_cyc - a), 2);
         end
      end
      tick(10);
      chk("t6_idle", bus.busy, 0);
      chk("t6_acks", ack_n, 3);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
